// File: rtl/deser_pkg.sv
// Shared constants and state encoding for the serial-to-parallel deserializer.
package deser_pkg;

  localparam int DESER_W     = 16;
  localparam int DESER_MOD_W = 4;
  localparam int DESER_CNT_W = $clog2(DESER_W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } deser_state_t;

endpackage

// File: rtl/deser_idle_timer.sv
// Idle-cycle counter for the deserializer: counts stalled cycles while a partial
// word is held and flags when the configured timeout has been reached.
module deser_idle_timer #(
  parameter int TIMEOUT = 32
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic count_en,
  input  logic clear,
  output logic timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] idle_cnt_q;

  // Saturates at LIMIT so the flag stays up until the owner clears it.
  always_ff @(posedge clk_i) begin
    if (srst_i || clear) begin
      idle_cnt_q <= '0;
    end else if (count_en && (idle_cnt_q != LIMIT)) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  assign timeout = (idle_cnt_q == LIMIT);

endmodule

// File: rtl/deserializer.sv
// Packs a valid-qualified serial stream MSB-first into W-bit words with a one-cycle
// valid pulse. Define DESER_IDLE_FLUSH_EN to flush partial words after an idle timeout.
//
//   state | meaning
//   IDLE  | no bits held, waiting for bit 1 of a word
//   RECV  | partial word held in the shift register
module deserializer
  import deser_pkg::*;
#(
  parameter int W            = DESER_W,
  parameter int IDLE_TIMEOUT = 32
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   ser_data_i,
  input  logic                   ser_data_val_i,
  output logic [W-1:0]           deser_data_o,
  output logic [DESER_MOD_W-1:0] deser_data_mod_o,
  output logic                   deser_data_val_o,
  output logic                   busy_o
);

  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  if (W < 4 || W > 16) begin : g_bad_w
    $error("deserializer: W must be in 4..16");
  end
  if (IDLE_TIMEOUT < 1) begin : g_bad_timeout
    $error("deserializer: IDLE_TIMEOUT must be positive");
  end

  deser_state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     shift_q;
  logic [W-1:0]     shift_next;

  assign shift_next = {shift_q[W-2:0], ser_data_i};
  assign busy_o     = (state_q == RECV);

`ifdef DESER_IDLE_FLUSH_EN
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);

  logic             timer_count_en;
  logic             timer_clear;
  logic             timeout;
  logic             flush;
  logic [CNT_W-1:0] flush_shamt;

  assign timer_count_en = (state_q == RECV) && !ser_data_val_i;
  assign timer_clear    = ser_data_val_i || (state_q == IDLE);
  // A valid bit on the timeout cycle takes priority, so flush requires no bit.
  assign flush          = timeout && (state_q == RECV) && !ser_data_val_i;
  assign flush_shamt    = CNT_FULL - cnt_q;

  deser_idle_timer #(
    .TIMEOUT (IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk_i    (clk_i),
    .srst_i   (srst_i),
    .count_en (timer_count_en),
    .clear    (timer_clear),
    .timeout  (timeout)
  );
`endif

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      shift_q          <= '0;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      if (ser_data_val_i) begin
        if (cnt_q == CNT_LAST) begin
          deser_data_o     <= shift_next;
          deser_data_mod_o <= '0;
          deser_data_val_o <= 1'b1;
          shift_q          <= '0;
          cnt_q            <= '0;
          state_q          <= IDLE;
        end else begin
          shift_q <= shift_next;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= RECV;
        end
`ifdef DESER_IDLE_FLUSH_EN
      end else if (flush) begin
        // Held bits sit in the low cnt positions; left-align them for the consumer.
        deser_data_o     <= shift_q << flush_shamt;
        deser_data_mod_o <= DESER_MOD_W'(cnt_q);
        deser_data_val_o <= 1'b1;
        shift_q          <= '0;
        cnt_q            <= '0;
        state_q          <= IDLE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer (W=16, IDLE_TIMEOUT=32).
module tb_deserializer;

  localparam int W = 16;

  logic         clk_i = 1'b0;
  logic         srst_i;
  logic         ser_data_i;
  logic         ser_data_val_i;
  logic [W-1:0] deser_data_o;
  logic [3:0]   deser_data_mod_o;
  logic         deser_data_val_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] pd[$];
  logic [3:0]   pm[$];
  int           pc[$];

  deserializer #(.W(W), .IDLE_TIMEOUT(32)) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every output pulse away from the active edge.
  always @(negedge clk_i) begin
    if (deser_data_val_o === 1'b1) begin
      pd.push_back(deser_data_o);
      pm.push_back(deser_data_mod_o);
      pc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_log();
    pd.delete();
    pm.delete();
    pc.delete();
  endtask

  task automatic drive_bit(input logic b);
    ser_data_i     = b;
    ser_data_val_i = 1'b1;
    tick();
    ser_data_val_i = 1'b0;
  endtask

  task automatic test_reset();
    srst_i         = 1'b1;
    ser_data_i     = 1'b1;
    ser_data_val_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (deser_data_o !== 16'h0000 || deser_data_mod_o !== 4'h0 ||
          deser_data_val_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs data=%h mod=%h val=%b busy=%b want all zero",
                 deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o);
      end
    end
    srst_i         = 1'b0;
    ser_data_val_i = 1'b0;
    tick();
    checks++;
    if (pd.size() != 0) begin
      errors++;
      $display("FAIL reset_no_pulse got %0d pulses want 0", pd.size());
    end
  endtask

  task automatic test_single_word();
    logic [15:0] w;
    w = 16'hAAAA;
    clear_log();
    for (int i = 15; i >= 0; i--) begin
      drive_bit(w[i]);
      if (i > 0) begin
        checks++;
        if (deser_data_val_o !== 1'b0) begin
          errors++;
          $display("FAIL single_early_pulse at bit %0d got val=%b want 0", 15 - i, deser_data_val_o);
        end
      end
    end
    checks++;
    if (deser_data_val_o !== 1'b1 || deser_data_o !== 16'hAAAA || deser_data_mod_o !== 4'h0) begin
      errors++;
      $display("FAIL single_word val=%b data=%h mod=%h want 1 aaaa 0",
               deser_data_val_o, deser_data_o, deser_data_mod_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_after got %b want 0", busy_o);
    end
    tick();
    checks++;
    if (deser_data_val_o !== 1'b0 || deser_data_o !== 16'hAAAA) begin
      errors++;
      $display("FAIL single_pulse_width val=%b data=%h want 0 aaaa", deser_data_val_o, deser_data_o);
    end
    checks++;
    if (pd.size() != 1) begin
      errors++;
      $display("FAIL single_pulse_count got %0d want 1", pd.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] stream;
    stream = 32'h1234_FFFF;
    clear_log();
    for (int i = 31; i >= 0; i--) drive_bit(stream[i]);
    tick();
    checks++;
    if (pd.size() != 2) begin
      errors++;
      $display("FAIL b2b_pulse_count got %0d want 2", pd.size());
    end else begin
      checks++;
      if (pd[0] !== 16'h1234 || pd[1] !== 16'hFFFF) begin
        errors++;
        $display("FAIL b2b_words got %h %h want 1234 ffff", pd[0], pd[1]);
      end
      checks++;
      if (pc[1] - pc[0] != 16) begin
        errors++;
        $display("FAIL b2b_spacing got %0d cycles want 16", pc[1] - pc[0]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [15:0] w;
    w = 16'h8001;
    clear_log();
    for (int i = 15; i >= 0; i--) begin
      drive_bit(w[i]);
      if (i > 0) begin
        for (int g = 0; g < 4; g++) begin
          if (g > 0) tick();
          checks++;
          if (busy_o !== 1'b1 || deser_data_val_o !== 1'b0) begin
            errors++;
            $display("FAIL gaps_hold bit %0d gap %0d busy=%b val=%b want 1 0",
                     15 - i, g, busy_o, deser_data_val_o);
          end
        end
      end
    end
    checks++;
    if (deser_data_val_o !== 1'b1 || deser_data_o !== 16'h8001 || deser_data_mod_o !== 4'h0) begin
      errors++;
      $display("FAIL gaps_word val=%b data=%h mod=%h want 1 8001 0",
               deser_data_val_o, deser_data_o, deser_data_mod_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] w;
    w = 16'h00FF;
    clear_log();
    for (int i = 0; i < 7; i++) drive_bit(1'b1);
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || deser_data_val_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state busy=%b val=%b want 0 0", busy_o, deser_data_val_o);
    end
    for (int i = 15; i >= 0; i--) drive_bit(w[i]);
    tick();
    checks++;
    if (pd.size() != 1) begin
      errors++;
      $display("FAIL midreset_pulse_count got %0d want 1", pd.size());
    end else begin
      checks++;
      if (pd[0] !== 16'h00FF) begin
        errors++;
        $display("FAIL midreset_word got %h want 00ff", pd[0]);
      end
    end
  endtask

  task automatic test_idle_flush();
    logic [4:0] bits;
    int first;
    bits  = 5'b11011;
    first = 0;
    clear_log();
    for (int i = 4; i >= 0; i--) drive_bit(bits[i]);
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (first == 0 && deser_data_val_o === 1'b1) first = n;
    end
`ifdef DESER_IDLE_FLUSH_EN
    checks++;
    if (first < 32 || first > 33) begin
      errors++;
      $display("FAIL flush_timing pulse after %0d idle cycles want 32..33", first);
    end
    checks++;
    if (pd.size() != 1) begin
      errors++;
      $display("FAIL flush_pulse_count got %0d want 1", pd.size());
    end else begin
      checks++;
      if (pd[0] !== 16'hD800 || pm[0] !== 4'd5) begin
        errors++;
        $display("FAIL flush_word data=%h mod=%0d want d800 5", pd[0], pm[0]);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy got %b want 0", busy_o);
    end
`else
    checks++;
    if (first != 0 || pd.size() != 0) begin
      errors++;
      $display("FAIL hold_no_flush got %0d pulses want 0", pd.size());
    end
    checks++;
    if (busy_o !== 1'b1 || deser_data_mod_o !== 4'h0) begin
      errors++;
      $display("FAIL hold_state busy=%b mod=%h want 1 0", busy_o, deser_data_mod_o);
    end
`endif
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    tick();
  endtask

  initial begin
    srst_i         = 1'b0;
    ser_data_i     = 1'b0;
    ser_data_val_i = 1'b0;
    #1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gaps();
    test_reset_mid_word();
    test_idle_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
